req_arbiter: RTL and testbench

Sequential 8-way arbiter that shares a single downstream resource among eight requesters, with registered one-hot and binary-encoded grants plus an idle flag. Round-robin by default. A fixed-priority mode, where the highest index wins, matches the priority-encoder convention used elsewhere in the lab datapath. It sits in front of the shared resource and drives its select lines. A hold-limit counter prevents any single requester from monopolising the resource.

---
 rtl/req_arbiter.sv | 132 +++++++++++++
 tb/tb_req_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// req_arbiter: 8-way round-robin / fixed-priority arbiter with registered
// one-hot and encoded grants, an idle flag and a hold-limit counter that
// forces rotation when one requester keeps the resource while others wait.
module req_arbiter #(
    parameter int unsigned N_REQ    = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             fixed_pri,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             idle
);

    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  last;
    logic [HW-1:0]     hcnt;

    logic [N_REQ-1:0]  cand;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_onehot;

    // Returns {found, index}. Round-robin searches last+1, last+2, ... with
    // wrap; fixed mode picks the highest set bit. Loops run in reverse search
    // order so the first candidate in search order is the final assignment.
    function automatic logic [IDX_W:0] arb(
        input logic [N_REQ-1:0] c,
        input logic [IDX_W-1:0] lst,
        input logic             fixed
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        int unsigned      k;
        found = 1'b0;
        idx   = '0;
        if (fixed) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (c[i]) begin
                    found = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int unsigned i = N_REQ; i >= 1; i--) begin
                k = (32'(lst) + i) % N_REQ;
                if (c[k]) begin
                    found = 1'b1;
                    idx   = IDX_W'(k);
                end
            end
        end
        return {found, idx};
    endfunction

    // Candidates exclude the current owner; gnt is all-zero in IDLE so the
    // same arbiter serves both the initial grant and release/timeout.
    always_comb begin
        cand                 = req & ~gnt;
        {win_found, win_idx} = arb(cand, last, fixed_pri);
        win_onehot           = N_REQ'(1) << win_idx;
    end

    // Single-process FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            idle      <= 1'b1;
            last      <= IDX_W'(N_REQ - 1);
            hcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= OWNED;
                        gnt       <= win_onehot;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        idle      <= 1'b0;
                        last      <= win_idx;
                        hcnt      <= '0;
                    end
                end
                OWNED: begin
                    if (!req[gnt_idx]) begin
                        if (win_found) begin
                            gnt     <= win_onehot;
                            gnt_idx <= win_idx;
                            last    <= win_idx;
                            hcnt    <= '0;
                        end else begin
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_idx   <= '0;
                            gnt_valid <= 1'b0;
                            idle      <= 1'b1;
                            hcnt      <= '0;
                        end
                    end else if (hcnt == HOLD_LAST) begin
                        if (win_found) begin
                            gnt     <= win_onehot;
                            gnt_idx <= win_idx;
                            last    <= win_idx;
                        end
                        hcnt <= '0;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed sequence plus a random phase; a behavioural model
// pushes expected outputs to a scoreboard queue each cycle and the values are
// popped and compared #1 after the clock edge. Key points also get constant
// checks taken directly from the intended behaviour.
module tb_req_arbiter;

    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       fixed_pri;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       idle;

    // 10-unit clock
    always #5 clk = ~clk;

    req_arbiter #(
        .N_REQ   (8),
        .IDX_W   (3),
        .MAX_HOLD(MH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .fixed_pri(fixed_pri),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .idle     (idle)
    );

    typedef struct {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    int m_owner = -1;
    int m_last  = 7;
    int m_hcnt  = 0;

    function automatic int m_arb(input logic [7:0] c, input int lst, input logic fp);
        if (fp) begin
            for (int b = 7; b >= 0; b--) begin
                if (c[b]) return b;
            end
        end else begin
            for (int s = 1; s <= 8; s++) begin
                if (c[(lst + s) % 8]) return (lst + s) % 8;
            end
        end
        return -1;
    endfunction

    task automatic model(input logic [7:0] r, input logic fp, input logic rs);
        logic [7:0] c;
        int         w;
        if (rs) begin
            m_owner = -1;
            m_last  = 7;
            m_hcnt  = 0;
        end else if (m_owner < 0) begin
            w = m_arb(r, m_last, fp);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_hcnt  = 0;
            end
        end else begin
            c = r;
            c[m_owner] = 1'b0;
            w = m_arb(c, m_last, fp);
            if (!r[m_owner]) begin
                m_owner = w;
                if (w >= 0) m_last = w;
                m_hcnt = 0;
            end else if (m_hcnt == MH - 1) begin
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                end
                m_hcnt = 0;
            end else begin
                m_hcnt = m_hcnt + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Drive one cycle of stimulus, queue the expected result, compare after edge.
    task automatic cyc(input logic [7:0] r, input logic fp, input logic rs);
        exp_t e;
        req       = r;
        fixed_pri = fp;
        rst       = rs;
        model(r, fp, rs);
        e.g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.i = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.v = (m_owner >= 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sb_gnt", 32'(gnt), 32'(e.g));
            chk("sb_idx", 32'(gnt_idx), 32'(e.i));
            chk("sb_valid", 32'(gnt_valid), 32'(e.v));
            chk("sb_idle", 32'(idle), 32'(!e.v));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        logic       fp;
        logic       rs;

        req = 8'h00; fixed_pri = 1'b0; rst = 1'b1;

        // Reset and first grant
        cyc(8'hFF, 1'b0, 1'b1);
        cyc(8'hFF, 1'b0, 1'b1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_gnt", 32'(gnt), 32'h00);
        cyc(8'hFF, 1'b0, 1'b0);
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_idx", 32'(gnt_idx), 32'd0);
        chk("first_idle", 32'(idle), 32'd0);

        // Back-to-back rotation: owner 0 releases, 1 takes over, then 1 releases
        repeat (3) cyc(8'h0A, 1'b0, 1'b0);
        chk("b2b_own1", 32'(gnt), 32'h02);
        cyc(8'h08, 1'b0, 1'b0);
        chk("b2b_gnt3", 32'(gnt), 32'h08);
        chk("b2b_idx3", 32'(gnt_idx), 32'd3);
        chk("b2b_valid", 32'(gnt_valid), 32'd1);

        // Release to idle
        cyc(8'h00, 1'b0, 1'b0);
        chk("rel_idle", 32'(idle), 32'd1);
        chk("rel_gnt", 32'(gnt), 32'h00);

        // Timeout: last=3, so 7 wins first, then alternation every 16 cycles
        cyc(8'h81, 1'b0, 1'b0);
        chk("to_first", 32'(gnt), 32'h80);
        repeat (15) cyc(8'h81, 1'b0, 1'b0);
        chk("to_hold16", 32'(gnt), 32'h80);
        cyc(8'h81, 1'b0, 1'b0);
        chk("to_rot01", 32'(gnt), 32'h01);
        repeat (15) cyc(8'h81, 1'b0, 1'b0);
        chk("to_hold01", 32'(gnt), 32'h01);
        cyc(8'h81, 1'b0, 1'b0);
        chk("to_rot80", 32'(gnt), 32'h80);

        // Sole requester keeps the grant through hold-limit expiries
        repeat (40) cyc(8'h01, 1'b0, 1'b0);
        chk("solo_keep", 32'(gnt), 32'h01);

        // Fixed priority from idle
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h26, 1'b1, 1'b0);
        chk("fp_gnt", 32'(gnt), 32'h20);
        chk("fp_idx", 32'(gnt_idx), 32'd5);
        repeat (2) cyc(8'h26, 1'b1, 1'b0);
        cyc(8'h06, 1'b1, 1'b0);
        chk("fp_rel", 32'(gnt), 32'h04);
        repeat (5) cyc(8'h86, 1'b1, 1'b0);
        chk("fp_nopre", 32'(gnt), 32'h04);

        // Mid-ownership reset, then first grant follows last=7
        cyc(8'h86, 1'b1, 1'b1);
        chk("mrst_gnt", 32'(gnt), 32'h00);
        chk("mrst_idle", 32'(idle), 32'd1);
        chk("mrst_valid", 32'(gnt_valid), 32'd0);
        cyc(8'hFF, 1'b0, 1'b0);
        chk("mrst_next", 32'(gnt), 32'h01);

        // Random phase: requests mostly persist so timeouts are exercised
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : req;
            fp = ($urandom_range(0, 7) == 0) ? ~fixed_pri : fixed_pri;
            rs = ($urandom_range(0, 99) == 0);
            cyc(r, fp, rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
